// File: rtl/ble_button_parser_if.sv
// Byte-stream and command bus for the Bluefruit button parser.
// The master side feeds UART bytes in and observes decoded commands;
// the slave side is the parser itself.
interface ble_button_parser_if;
    logic [7:0] data_in;
    logic       valid_in;
    logic       cmd_valid_out;
    logic [2:0] btn_id_out;
    logic       pressed_out;
    logic [7:0] held_out;
    logic       err_out;
    logic [7:0] err_count_out;

    modport master (
        output data_in,
        output valid_in,
        input  cmd_valid_out,
        input  btn_id_out,
        input  pressed_out,
        input  held_out,
        input  err_out,
        input  err_count_out
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output cmd_valid_out,
        output btn_id_out,
        output pressed_out,
        output held_out,
        output err_out,
        output err_count_out
    );
endinterface

// File: rtl/ble_button_parser.sv
// Bluefruit controller-pad button packet parser.
// Frames "!B<id><state><crc>" packets out of the raw UART byte stream,
// verifies the additive checksum and emits one single-cycle command per
// good packet, a held-button bitmap and a saturating rejected-packet count.
// A partial packet that stalls for TIMEOUT_CYCLES idle cycles is dropped.
module ble_button_parser #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic               clk_in,
    input  logic               rst_in,
    ble_button_parser_if.slave bus
);

    // The gap counter only needs to reach TIMEOUT_CYCLES-1: the timeout
    // fires on the idle cycle that would have taken it to TIMEOUT_CYCLES.
    localparam int unsigned GAP_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] BYTE_BANG   = 8'h21;
    localparam logic [7:0] BYTE_BUTTON = 8'h42;
    localparam logic [7:0] BYTE_ID_LO  = 8'h31;
    localparam logic [7:0] BYTE_ID_HI  = 8'h38;
    localparam logic [7:0] BYTE_REL    = 8'h30;
    localparam logic [7:0] BYTE_PRESS  = 8'h31;

    typedef enum logic [2:0] {
        IDLE,
        GOT_BANG,
        GOT_TYPE,
        GOT_ID,
        GOT_STATE
    } state_t;

    state_t           r_state;
    logic [7:0]       r_acc;
    logic [GAP_W-1:0] r_gap;
    logic [2:0]       r_pendId;
    logic             r_pendPressed;

    logic             r_cmdValid;
    logic [2:0]       r_btnId;
    logic             r_pressed;
    logic [7:0]       r_held;
    logic             r_err;
    logic [7:0]       r_errCount;

    logic             w_isBang;
    logic             w_isButton;
    logic             w_idOk;
    logic             w_stateOk;
    logic             w_crcOk;
    logic [2:0]       w_idIndex;
    logic             w_byteOk;
    logic             w_byteErr;
    logic             w_timeout;
    logic             w_errEvent;
    logic             w_commit;

    // Classify the incoming byte against each field of the packet format.
    // The id is encoded as ASCII '1'..'8'; its low three bits minus one give
    // the button index, with '8' (low bits 000) wrapping round to 7.
    always_comb begin
        w_isBang   = (bus.data_in == BYTE_BANG);
        w_isButton = (bus.data_in == BYTE_BUTTON);
        w_idOk     = (bus.data_in >= BYTE_ID_LO) && (bus.data_in <= BYTE_ID_HI);
        w_stateOk  = (bus.data_in == BYTE_REL) || (bus.data_in == BYTE_PRESS);
        w_crcOk    = (bus.data_in == ~r_acc);
        w_idIndex  = bus.data_in[2:0] - 3'd1;
    end

    // Decide whether the current byte is acceptable in the current state and
    // whether this cycle produces an error or a commit. A repeated '!' while
    // waiting for 'B' is treated as a fresh packet start rather than an error.
    always_comb begin
        w_byteOk = 1'b0;
        case (r_state)
            IDLE:      w_byteOk = w_isBang;
            GOT_BANG:  w_byteOk = w_isButton || w_isBang;
            GOT_TYPE:  w_byteOk = w_idOk;
            GOT_ID:    w_byteOk = w_stateOk;
            GOT_STATE: w_byteOk = w_crcOk;
            default:   w_byteOk = 1'b0;
        endcase

        w_byteErr  = bus.valid_in && (r_state != IDLE) && !w_byteOk;
        w_timeout  = !bus.valid_in && (r_state != IDLE) && (r_gap == GAP_LAST);
        w_errEvent = w_byteErr || w_timeout;
        w_commit   = bus.valid_in && (r_state == GOT_STATE) && w_crcOk;
    end

    // Packet framing FSM with the running checksum and the pending id/state.
    // A rejected byte that is itself '!' restarts framing in GOT_BANG so a
    // packet that begins right after a broken one is not lost.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state       <= IDLE;
            r_acc         <= 8'h00;
            r_pendId      <= 3'd0;
            r_pendPressed <= 1'b0;
        end else if (w_errEvent) begin
            if (w_byteErr && w_isBang) begin
                r_state <= GOT_BANG;
                r_acc   <= BYTE_BANG;
            end else begin
                r_state <= IDLE;
            end
        end else if (bus.valid_in) begin
            case (r_state)
                IDLE: begin
                    if (w_isBang) begin
                        r_state <= GOT_BANG;
                        r_acc   <= BYTE_BANG;
                    end
                end
                GOT_BANG: begin
                    if (w_isButton) begin
                        r_state <= GOT_TYPE;
                        r_acc   <= r_acc + bus.data_in;
                    end else begin
                        r_acc   <= BYTE_BANG;
                    end
                end
                GOT_TYPE: begin
                    r_state  <= GOT_ID;
                    r_acc    <= r_acc + bus.data_in;
                    r_pendId <= w_idIndex;
                end
                GOT_ID: begin
                    r_state       <= GOT_STATE;
                    r_acc         <= r_acc + bus.data_in;
                    r_pendPressed <= bus.data_in[0];
                end
                GOT_STATE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Inter-byte gap counter: cleared by every strobe, idle in IDLE, and
    // cleared again when it expires so the next packet starts from zero.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_gap <= '0;
        end else if (bus.valid_in || (r_state == IDLE) || w_timeout) begin
            r_gap <= '0;
        end else begin
            r_gap <= r_gap + GAP_W'(1);
        end
    end

    // Registered command outputs: pulse on commit and update the held bitmap.
    // Releasing a button that is not held simply rewrites a zero.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_cmdValid <= 1'b0;
            r_btnId    <= 3'd0;
            r_pressed  <= 1'b0;
            r_held     <= 8'h00;
        end else begin
            r_cmdValid <= w_commit;
            if (w_commit) begin
                r_btnId          <= r_pendId;
                r_pressed        <= r_pendPressed;
                r_held[r_pendId] <= r_pendPressed;
            end
        end
    end

    // Registered error pulse and its saturating statistics counter.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_err      <= 1'b0;
            r_errCount <= 8'h00;
        end else begin
            r_err <= w_errEvent;
            if (w_errEvent && (r_errCount != 8'hFF)) begin
                r_errCount <= r_errCount + 8'd1;
            end
        end
    end

    assign bus.cmd_valid_out = r_cmdValid;
    assign bus.btn_id_out    = r_btnId;
    assign bus.pressed_out   = r_pressed;
    assign bus.held_out      = r_held;
    assign bus.err_out       = r_err;
    assign bus.err_count_out = r_errCount;

endmodule

// File: tb/tb_ble_button_parser.sv
// Testbench for ble_button_parser.
// A packet-level model (byte queue plus idle-gap count) predicts every
// output each cycle; directed scenarios add hand-computed literal checks.
module tb_ble_button_parser;

    localparam int unsigned T = 100;

    logic clk;
    logic rst;

    ble_button_parser_if bus ();

    ble_button_parser #(
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    int checks;
    int errors;
    bit checkEn;

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state.
    logic [7:0] mPkt[$];
    int         mGap;
    logic       mCmd;
    logic       mErr;
    logic [2:0] mId;
    logic       mPressed;
    logic [7:0] mHeld;
    logic [7:0] mErrCount;
    logic [7:0] mSum;
    logic [7:0] mCrc;
    logic [7:0] mByte;
    int         mPos;
    bit         mFits;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] b);
        @(negedge clk);
        bus.valid_in = v;
        bus.data_in  = b;
    endtask

    // Sends the first n bytes of seq (MSB first), with gap idle cycles
    // between consecutive bytes; the last byte is left driven.
    task automatic sendSeq(input logic [39:0] seq, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, seq[39 - 8*i -: 8]);
            if (i < n - 1) begin
                repeat (gap) applyStimulus(1'b0, 8'h00);
            end
        end
    endtask

    // Packet-level model: the queue holds the bytes of the packet in progress.
    // Each new byte must fit the field at its position; the fifth byte must be
    // the complement of the 8-bit sum of the first four.
    always @(posedge clk) begin
        mCmd = 1'b0;
        mErr = 1'b0;
        if (!rst) begin
            mPkt.delete();
            mGap      = 0;
            mId       = 3'd0;
            mPressed  = 1'b0;
            mHeld     = 8'h00;
            mErrCount = 8'h00;
        end else if (bus.valid_in) begin
            mByte = bus.data_in;
            mGap  = 0;
            mPos  = mPkt.size();
            if (mPos == 0) begin
                if (mByte == 8'h21) mPkt.push_back(mByte);
            end else begin
                mSum = 8'h00;
                foreach (mPkt[k]) mSum = mSum + mPkt[k];
                mCrc = ~mSum;
                case (mPos)
                    1:       mFits = (mByte == 8'h42);
                    2:       mFits = (mByte >= 8'h31) && (mByte <= 8'h38);
                    3:       mFits = (mByte == 8'h30) || (mByte == 8'h31);
                    default: mFits = (mByte == mCrc);
                endcase
                if (mFits && mPos == 4) begin
                    mId            = 3'(mPkt[2] - 8'h31);
                    mPressed       = (mPkt[3] == 8'h31);
                    mHeld[mId]     = mPressed;
                    mCmd           = 1'b1;
                    mPkt.delete();
                end else if (mFits) begin
                    mPkt.push_back(mByte);
                end else if (mPos == 1 && mByte == 8'h21) begin
                    mPkt.delete();
                    mPkt.push_back(mByte);
                end else begin
                    mErr = 1'b1;
                    if (mErrCount != 8'hFF) mErrCount = mErrCount + 8'd1;
                    mPkt.delete();
                    if (mByte == 8'h21) mPkt.push_back(mByte);
                end
            end
        end else if (mPkt.size() != 0) begin
            mGap++;
            if (mGap == int'(T)) begin
                mErr = 1'b1;
                if (mErrCount != 8'hFF) mErrCount = mErrCount + 8'd1;
                mPkt.delete();
                mGap = 0;
            end
        end
    end

    // Cycle-by-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("cmd_valid_out", 32'(bus.cmd_valid_out), 32'(mCmd));
            checkOutput("err_out", 32'(bus.err_out), 32'(mErr));
            checkOutput("btn_id_out", 32'(bus.btn_id_out), 32'(mId));
            checkOutput("pressed_out", 32'(bus.pressed_out), 32'(mPressed));
            checkOutput("held_out", 32'(bus.held_out), 32'(mHeld));
            checkOutput("err_count_out", 32'(bus.err_count_out), 32'(mErrCount));
        end
    end

    // Directed scenarios followed by randomized packet traffic.
    initial begin
        logic [39:0] seq;
        logic [7:0]  idB;
        logic [7:0]  stB;
        logic [7:0]  crcB;
        int          n;
        int          kind;
        int          pos;
        int          pulses;
        int          pulseAt;

        checks       = 0;
        errors       = 0;
        checkEn      = 1'b0;
        rst          = 1'b0;
        bus.valid_in = 1'b0;
        bus.data_in  = 8'h00;

        repeat (2) @(negedge clk);
        checkOutput("reset cmd_valid", 32'(bus.cmd_valid_out), 32'd0);
        checkOutput("reset err", 32'(bus.err_out), 32'd0);
        checkOutput("reset btn_id", 32'(bus.btn_id_out), 32'd0);
        checkOutput("reset pressed", 32'(bus.pressed_out), 32'd0);
        checkOutput("reset held", 32'(bus.held_out), 32'h00);
        checkOutput("reset err_count", 32'(bus.err_count_out), 32'd0);
        checkEn = 1'b1;
        rst     = 1'b1;

        $display("[TB] press button 5, bytes 10 cycles apart");
        sendSeq({8'h21, 8'h42, 8'h35, 8'h31, 8'h36}, 5, 10);
        applyStimulus(1'b0, 8'h00);
        checkOutput("press cmd_valid", 32'(bus.cmd_valid_out), 32'd1);
        checkOutput("press btn_id", 32'(bus.btn_id_out), 32'd4);
        checkOutput("press pressed", 32'(bus.pressed_out), 32'd1);
        checkOutput("press held", 32'(bus.held_out), 32'h10);
        applyStimulus(1'b0, 8'h00);
        checkOutput("press pulse width", 32'(bus.cmd_valid_out), 32'd0);

        $display("[TB] release button 5");
        sendSeq({8'h21, 8'h42, 8'h35, 8'h30, 8'h37}, 5, 10);
        applyStimulus(1'b0, 8'h00);
        checkOutput("release cmd_valid", 32'(bus.cmd_valid_out), 32'd1);
        checkOutput("release pressed", 32'(bus.pressed_out), 32'd0);
        checkOutput("release held", 32'(bus.held_out), 32'h00);
        checkOutput("release err_count", 32'(bus.err_count_out), 32'd0);

        $display("[TB] bad checksum");
        sendSeq({8'h21, 8'h42, 8'h35, 8'h31, 8'h00}, 5, 2);
        applyStimulus(1'b0, 8'h00);
        checkOutput("badcrc err", 32'(bus.err_out), 32'd1);
        checkOutput("badcrc cmd_valid", 32'(bus.cmd_valid_out), 32'd0);
        checkOutput("badcrc err_count", 32'(bus.err_count_out), 32'd1);
        checkOutput("badcrc held", 32'(bus.held_out), 32'h00);

        $display("[TB] resync on '!' inside a packet");
        applyStimulus(1'b1, 8'h21);
        applyStimulus(1'b1, 8'h42);
        applyStimulus(1'b1, 8'h35);
        applyStimulus(1'b1, 8'h21);
        applyStimulus(1'b1, 8'h42);
        checkOutput("resync err", 32'(bus.err_out), 32'd1);
        checkOutput("resync err_count", 32'(bus.err_count_out), 32'd2);
        applyStimulus(1'b1, 8'h31);
        applyStimulus(1'b1, 8'h31);
        applyStimulus(1'b1, 8'h3A);
        applyStimulus(1'b0, 8'h00);
        checkOutput("resync cmd_valid", 32'(bus.cmd_valid_out), 32'd1);
        checkOutput("resync btn_id", 32'(bus.btn_id_out), 32'd0);
        checkOutput("resync held", 32'(bus.held_out), 32'h01);

        $display("[TB] timeout after '!B'");
        sendSeq({8'h21, 8'h42, 24'h0}, 2, 0);
        pulses  = 0;
        pulseAt = 0;
        for (int k = 1; k <= int'(T) + 50; k++) begin
            applyStimulus(1'b0, 8'h00);
            if (bus.err_out) begin
                pulses++;
                pulseAt = k;
            end
        end
        checkOutput("timeout pulse count", 32'(pulses), 32'd1);
        checkOutput("timeout pulse cycle", 32'(pulseAt), 32'(T + 1));
        checkOutput("timeout err_count", 32'(bus.err_count_out), 32'd3);
        sendSeq({8'h21, 8'h42, 8'h38, 8'h31, 8'h33}, 5, 0);
        applyStimulus(1'b0, 8'h00);
        checkOutput("post-timeout cmd_valid", 32'(bus.cmd_valid_out), 32'd1);
        checkOutput("post-timeout held", 32'(bus.held_out), 32'h81);

        $display("[TB] byte arriving on the timeout cycle");
        sendSeq({8'h21, 8'h42, 8'h34, 8'h31, 8'h37}, 5, int'(T) - 1);
        applyStimulus(1'b0, 8'h00);
        checkOutput("edge cmd_valid", 32'(bus.cmd_valid_out), 32'd1);
        checkOutput("edge held", 32'(bus.held_out), 32'h89);
        checkOutput("edge err_count", 32'(bus.err_count_out), 32'd3);

        $display("[TB] randomized traffic");
        for (int p = 0; p < 150; p++) begin
            idB  = 8'h30 + 8'($urandom_range(1, 8));
            stB  = 8'h30 + 8'($urandom_range(0, 1));
            crcB = ~(8'h21 + 8'h42 + idB + stB);
            seq  = {8'h21, 8'h42, idB, stB, crcB};
            n    = 5;
            kind = $urandom_range(0, 9);
            case (kind)
                0: seq[7:0] = seq[7:0] ^ 8'(1 << $urandom_range(0, 7));
                1: begin
                    pos = $urandom_range(1, 3);
                    seq[39 - 8*pos -: 8] = 8'($urandom);
                end
                2: n = $urandom_range(1, 4);
                3: begin
                    repeat ($urandom_range(1, 4)) applyStimulus(1'b1, 8'($urandom));
                end
                default: ;
            endcase
            sendSeq(seq, n, $urandom_range(0, 2));
            if (kind == 2) begin
                repeat (int'(T) + 3) applyStimulus(1'b0, 8'h00);
            end else begin
                repeat ($urandom_range(1, 3)) applyStimulus(1'b0, 8'h00);
            end
        end

        $display("[TB] error counter saturation");
        for (int p = 0; p < 300; p++) begin
            sendSeq({8'h21, 8'h58, 24'h0}, 2, 0);
        end
        applyStimulus(1'b0, 8'h00);
        checkOutput("saturated err_count", 32'(bus.err_count_out), 32'd255);

        $display("[TB] reset mid-packet");
        sendSeq({8'h21, 8'h42, 8'h35, 16'h0}, 3, 0);
        @(negedge clk);
        bus.valid_in = 1'b0;
        rst          = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checkOutput("midreset cmd_valid", 32'(bus.cmd_valid_out), 32'd0);
        checkOutput("midreset err", 32'(bus.err_out), 32'd0);
        checkOutput("midreset btn_id", 32'(bus.btn_id_out), 32'd0);
        checkOutput("midreset pressed", 32'(bus.pressed_out), 32'd0);
        checkOutput("midreset held", 32'(bus.held_out), 32'h00);
        checkOutput("midreset err_count", 32'(bus.err_count_out), 32'd0);
        repeat (int'(T) + 5) applyStimulus(1'b0, 8'h00);
        checkOutput("midreset no late err", 32'(bus.err_count_out), 32'd0);

        checkEn = 1'b0;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
